// File: rtl/midi_msg_rx_pkg.sv
// MIDI message types, status-nibble and system-byte constants, and small decode helpers.
// Shared by the receiver top, its interface and the testbench.
package midi_msg_rx_pkg;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
  } midi_msg_t;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam logic [7:0] SYSEX  = 8'hF0;
  localparam logic [7:0] EOX    = 8'hF7;
  localparam logic [7:0] RT_MIN = 8'hF8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_NEED1, ST_NEED2, ST_SYSEX, ST_SKIP1, ST_SKIP2
  } parse_state_e;

  function automatic logic [1:0] data_bytes(input logic [7:0] st);
    case (st[7:4])
      PROG, CH_AT:                         return 2'd1;
      NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: return 2'd2;
      default:                             return 2'd0;
    endcase
  endfunction

  // Note-On with velocity 0 is a Note-Off in disguise; optionally rewrite it.
  function automatic midi_msg_t make_msg(input logic [7:0] st, input logic [7:0] d1,
                                         input logic [7:0] d2, input logic normalize);
    midi_msg_t m;
    m.status = st;
    m.data1  = d1;
    m.data2  = d2;
    if (normalize && st[7:4] == NOTE_ON && d2 == 8'h00) m.status = {NOTE_OFF, st[3:0]};
    return m;
  endfunction

endpackage

// File: rtl/midi_msg_rx_if.sv
// Message output bundle of the MIDI receiver: ready/valid head-of-FIFO plus sticky overflow flag.
interface midi_msg_rx_if;
  import midi_msg_rx_pkg::*;

  logic      msg_valid_out;
  logic      msg_ready_in;
  midi_msg_t msg_out;
  logic      overflow_out;

  modport master (output msg_valid_out, output msg_out, output overflow_out, input msg_ready_in);
  modport slave  (input msg_valid_out, input msg_out, input overflow_out, output msg_ready_in);
endinterface

// File: rtl/midi_msg_fifo.sv
// Synchronous ready/valid FIFO, one cycle push-to-valid; a push while full succeeds only with a same-cycle pop.
// pop_in is ignored while empty; head reads as zero when empty.
module midi_msg_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] push_dat_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] pop_dat_out,
  output logic             full_out,
  output logic             empty_out
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_out   = (count_q == '0);
  assign full_out    = (count_q == CNTW'(DEPTH));
  assign pop_dat_out = empty_out ? '0 : mem_q[rd_ptr_q];
  assign do_pop      = pop_in && !empty_out;
  assign do_push     = push_in && (!full_out || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + CNTW'(1);
    else if (!do_push && do_pop) count_d = count_q - CNTW'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, each bit sampled near its midpoint after a 2-flop synchroniser.
// byte_valid pulses one cycle per received byte; no backpressure, consume on the pulse.
module uart_rx #(
  parameter int CLOCKS_PER_BAUD = 32
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_in,
  output logic [7:0] byte_out,
  output logic       byte_valid
);
  localparam int CW = $clog2(CLOCKS_PER_BAUD + 1);
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BAUD / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          rx_s;

  assign rx_s       = sync_q[1];
  assign byte_out   = shift_q;
  assign byte_valid = valid_q;

  always_comb begin
    sync_d  = {sync_q[0], rx_in};
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else cnt_d = cnt_q + CW'(1);
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: begin
        // A low stop bit is a framing error: drop the byte silently.
        if (cnt_q == LAST) begin
          valid_d = rx_s;
          state_d = RX_IDLE;
        end else cnt_d = cnt_q + CW'(1);
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= RX_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/midi_msg_rx.sv
// Serial MIDI in -> framed channel-voice messages (running status, realtime skip, channel filter) in a FIFO.
// Valid one cycle after the final byte; ready/valid out, completed messages dropped with sticky overflow when full.
module midi_msg_rx
  import midi_msg_rx_pkg::*;
#(
  parameter int          CLOCKS_PER_BAUD    = 32,
  parameter int          FIFO_DEPTH         = 4,
  parameter logic [15:0] CHANNEL_MASK       = 16'hFFFF,
  parameter bit          NORMALIZE_NOTE_OFF = 1'b1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rx_in,
  midi_msg_rx_if.master msg_if
);
  logic         byte_vld;
  logic [7:0]   rx_byte;
  parse_state_e state_q, state_d;
  logic [7:0]   rs_q, rs_d, stat_q, stat_d, d1_q, d1_d;
  logic         rs_vld_q, rs_vld_d, overflow_q, overflow_d;
  logic [7:0]   first_st;
  logic         done, push, fifo_full, fifo_empty;
  midi_msg_t    done_msg;
  logic [23:0]  head;

  uart_rx #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_uart (
    .clk_in(clk_in), .rst_in(rst_in), .rx_in(rx_in),
    .byte_out(rx_byte), .byte_valid(byte_vld)
  );

  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    rs_vld_d = rs_vld_q;
    stat_d   = stat_q;
    d1_d     = d1_q;
    done     = 1'b0;
    done_msg = '0;
    // In IDLE a data byte restarts the running-status message.
    first_st = (state_q == ST_IDLE) ? rs_q : stat_q;
    if (byte_vld && rx_byte < RT_MIN) begin
      if (rx_byte[7]) begin
        if (rx_byte < SYSEX) begin
          rs_d     = rx_byte;
          rs_vld_d = 1'b1;
          stat_d   = rx_byte;
          state_d  = ST_NEED1;
        end else begin
          rs_vld_d = 1'b0;
          case (rx_byte)
            SYSEX:        state_d = ST_SYSEX;
            8'hF1, 8'hF3: state_d = ST_SKIP1;
            8'hF2:        state_d = ST_SKIP2;
            EOX:          state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
          endcase
        end
      end else begin
        case (state_q)
          ST_IDLE, ST_NEED1: begin
            if (state_q == ST_NEED1 || rs_vld_q) begin
              stat_d = first_st;
              d1_d   = rx_byte;
              if (data_bytes(first_st) == 2'd1) begin
                done     = 1'b1;
                done_msg = make_msg(first_st, rx_byte, 8'h00, NORMALIZE_NOTE_OFF);
              end else state_d = ST_NEED2;
            end
          end
          ST_NEED2: begin
            done     = 1'b1;
            done_msg = make_msg(stat_q, d1_q, rx_byte, NORMALIZE_NOTE_OFF);
          end
          ST_SKIP2: state_d = ST_SKIP1;
          ST_SKIP1: state_d = ST_IDLE;
          default:  state_d = state_q;
        endcase
        if (done) state_d = ST_IDLE;
      end
    end
  end

  assign push = done && CHANNEL_MASK[done_msg.status[3:0]];
  // When full the head is valid, so a same-cycle pop is exactly msg_ready_in.
  assign overflow_d = overflow_q | (push & fifo_full & ~msg_if.msg_ready_in);

  midi_msg_fifo #(.WIDTH(24), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in(clk_in), .rst_in(rst_in),
    .push_in(push), .push_dat_in(done_msg),
    .pop_in(msg_if.msg_ready_in), .pop_dat_out(head),
    .full_out(fifo_full), .empty_out(fifo_empty)
  );

  assign msg_if.msg_valid_out = !fifo_empty;
  assign msg_if.msg_out       = head;
  assign msg_if.overflow_out  = overflow_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      rs_q       <= '0;
      rs_vld_q   <= 1'b0;
      stat_q     <= '0;
      d1_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      rs_vld_q   <= rs_vld_d;
      stat_q     <= stat_d;
      d1_q       <= d1_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_midi_msg_rx.sv
// Bench for midi_msg_rx: two instances (all channels + note-off rewrite; channel 0 only, no rewrite).
module tb_midi_msg_rx;
  import midi_msg_rx_pkg::*;

  localparam int          CPB = 8;
  localparam logic [15:0] M2  = 16'h0001;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  midi_msg_rx_if bus1();
  midi_msg_rx_if bus2();

  midi_msg_rx #(.CLOCKS_PER_BAUD(CPB), .FIFO_DEPTH(4), .CHANNEL_MASK(16'hFFFF),
                .NORMALIZE_NOTE_OFF(1'b1)) dut (
    .clk_in(clk), .rst_in(rst), .rx_in(rx), .msg_if(bus1));
  midi_msg_rx #(.CLOCKS_PER_BAUD(CPB), .FIFO_DEPTH(4), .CHANNEL_MASK(M2),
                .NORMALIZE_NOTE_OFF(1'b0)) dut2 (
    .clk_in(clk), .rst_in(rst), .rx_in(rx), .msg_if(bus2));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [23:0] q1[$], q2[$], e1[$], e2[$];

  always @(negedge clk) begin
    if (!rst && bus1.msg_valid_out && bus1.msg_ready_in) q1.push_back(bus1.msg_out);
    if (!rst && bus2.msg_valid_out && bus2.msg_ready_in) q2.push_back(bus2.msg_out);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic check_q(input string nm, input bit second);
    int ng, ne;
    ng = second ? q2.size() : q1.size();
    ne = second ? e2.size() : e1.size();
    check({nm, " count"}, 32'(ng), 32'(ne));
    for (int i = 0; i < ne && i < ng; i++)
      check($sformatf("%s msg%0d", nm, i), second ? q2[i] : q1[i], second ? e2[i] : e1[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) step();
    end
    rx = 1'b1;
    repeat (CPB) step();
  endtask

  task automatic wait_byte_vld(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 * CPB; i++) begin
      step();
      if (dut.byte_vld) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: byte strobe never seen, got none, want one", nm);
    end
  endtask

  // Reference model: message-level framing from the MIDI rules.
  int m_rs, m_cur, m_skip;
  bit m_sysex;
  logic [7:0] m_dat[$];

  function automatic void model_reset();
    m_rs = -1; m_cur = -1; m_skip = 0; m_sysex = 1'b0;
    m_dat.delete();
  endfunction

  function automatic int msg_len(input int st);
    return ((st >> 4) == 12 || (st >> 4) == 13) ? 1 : 2;
  endfunction

  function automatic void emit(input int st, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] s;
    int ch;
    s  = st[7:0];
    ch = st & 15;
    e1.push_back({((st >> 4) == 9 && d2 == 0) ? {4'h8, s[3:0]} : s, d1, d2});
    if (M2[ch]) e2.push_back({s, d1, d2});
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'hF8) return;
    if (b[7]) begin
      m_cur = -1; m_dat.delete(); m_skip = 0; m_sysex = 1'b0;
      if (b < 8'hF0) begin
        m_rs = int'(b); m_cur = int'(b);
      end else begin
        m_rs = -1;
        m_sysex = (b == 8'hF0);
        m_skip = (b == 8'hF2) ? 2 : (b == 8'hF1 || b == 8'hF3) ? 1 : 0;
      end
      return;
    end
    if (m_sysex) return;
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    if (m_cur < 0) begin
      if (m_rs < 0) return;
      m_cur = m_rs;
    end
    m_dat.push_back(b);
    if (m_dat.size() == msg_len(m_cur)) begin
      emit(m_cur, m_dat[0], (m_dat.size() == 2) ? m_dat[1] : 8'h00);
      m_cur = -1;
      m_dat.delete();
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    q1.delete(); q2.delete(); e1.delete(); e2.delete();
    model_reset();
  endtask

  typedef struct packed {
    logic        rst;
    logic [3:0]  nb;
    logic [63:0] b;
    logic [1:0]  ne;
    logic [47:0] e;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl[NV];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit rnd_done;
    logic [7:0] rb[$];

    tbl[0]  = '{rst:1'b1, nb:4'd3, b:64'h903C64_0000000000, ne:2'd1, e:48'h903C64_000000};
    tbl[1]  = '{rst:1'b0, nb:4'd2, b:64'h3E40_000000000000, ne:2'd1, e:48'h903E40_000000};
    tbl[2]  = '{rst:1'b1, nb:4'd4, b:64'h903CF864_00000000, ne:2'd1, e:48'h903C64_000000};
    tbl[3]  = '{rst:1'b0, nb:4'd2, b:64'h3C00_000000000000, ne:2'd1, e:48'h803C00_000000};
    tbl[4]  = '{rst:1'b1, nb:4'd7, b:64'hF0010203F7C507_00, ne:2'd1, e:48'hC50700_000000};
    tbl[5]  = '{rst:1'b1, nb:4'd5, b:64'h903C64F740_000000, ne:2'd1, e:48'h903C64_000000};
    tbl[6]  = '{rst:1'b1, nb:4'd5, b:64'hB2077F0810_000000, ne:2'd2, e:48'hB2077F_B20810};
    tbl[7]  = '{rst:1'b1, nb:4'd5, b:64'hE10040FE02_000000, ne:2'd1, e:48'hE10040_000000};
    tbl[8]  = '{rst:1'b1, nb:4'd4, b:64'hF2010203_00000000, ne:2'd0, e:48'h0};
    tbl[9]  = '{rst:1'b1, nb:4'd5, b:64'h913CF11020_000000, ne:2'd0, e:48'h0};
    tbl[10] = '{rst:1'b1, nb:4'd3, b:64'hD43031_0000000000, ne:2'd2, e:48'hD43000_D43100};

    rst = 1'b1; rx = 1'b1;
    bus1.msg_ready_in = 1'b0; bus2.msg_ready_in = 1'b0;
    repeat (4) step();
    check("reset valid", 32'(bus1.msg_valid_out), 32'd0);
    check("reset msg", 32'(bus1.msg_out), 32'd0);
    check("reset overflow", 32'(bus1.overflow_out), 32'd0);

    bus1.msg_ready_in = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rst) do_reset();
      q1.delete(); e1.delete();
      for (int j = 0; j < int'(tbl[i].nb); j++) send_byte(tbl[i].b[63 - 8*j -: 8]);
      repeat (6) step();
      for (int k = 0; k < int'(tbl[i].ne); k++) e1.push_back(tbl[i].e[47 - 24*k -: 24]);
      check_q($sformatf("vec%0d", i), 1'b0);
    end

    // One-cycle latency from the final byte strobe to valid.
    do_reset();
    bus1.msg_ready_in = 1'b0;
    send_byte(8'h90); send_byte(8'h3C);
    fork
      send_byte(8'h64);
      begin
        wait_byte_vld("latency", ok);
        if (ok) begin
          check("latency valid before push", 32'(bus1.msg_valid_out), 32'd0);
          step();
          check("latency valid after push", 32'(bus1.msg_valid_out), 32'd1);
          check("latency msg", 32'(bus1.msg_out), 32'h903C64);
        end
      end
    join

    // Overflow: five messages into a four-deep FIFO with no consumer.
    do_reset();
    bus1.msg_ready_in = 1'b0;
    foreach (tbl[0].b[i]) begin end
    rb = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    foreach (rb[i]) send_byte(rb[i]);
    repeat (4) step();
    check("ovf flag", 32'(bus1.overflow_out), 32'd1);
    check("ovf head held", 32'(bus1.msg_out), 32'h903C64);
    e1 = '{24'h903C64, 24'h903E40, 24'h904142, 24'h904344};
    bus1.msg_ready_in = 1'b1;
    repeat (8) step();
    check_q("ovf drain", 1'b0);
    check("ovf drained valid", 32'(bus1.msg_valid_out), 32'd0);
    check("ovf sticky", 32'(bus1.overflow_out), 32'd1);
    do_reset();
    check("ovf cleared by reset", 32'(bus1.overflow_out), 32'd0);

    // Full FIFO, push and pop on the same edge: accepted, no overflow.
    bus1.msg_ready_in = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(rb[i]);
    fork
      send_byte(8'h46);
      begin
        wait_byte_vld("push+pop", ok);
        bus1.msg_ready_in = 1'b1;
        step();
        bus1.msg_ready_in = 1'b0;
      end
    join
    repeat (4) step();
    check("push+pop overflow", 32'(bus1.overflow_out), 32'd0);
    bus1.msg_ready_in = 1'b1;
    repeat (8) step();
    e1 = '{24'h903C64, 24'h903E40, 24'h904142, 24'h904344, 24'h904546};
    check_q("push+pop", 1'b0);

    // Channel filter and disabled note-off rewrite on the second instance.
    do_reset();
    bus1.msg_ready_in = 1'b1;
    bus2.msg_ready_in = 1'b0;
    send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
    repeat (6) step();
    check("mask inert valid", 32'(bus2.msg_valid_out), 32'd0);
    check("mask inert overflow", 32'(bus2.overflow_out), 32'd0);
    bus2.msg_ready_in = 1'b1;
    rb = '{8'h90, 8'h3C, 8'h64, 8'h3C, 8'h00};
    foreach (rb[i]) send_byte(rb[i]);
    repeat (6) step();
    e2 = '{24'h903C64, 24'h903C00};
    e1 = '{24'h913C64, 24'h903C64, 24'h803C00};
    check_q("mask ch0", 1'b1);
    check_q("mask all", 1'b0);

    // Reset mid-message discards FIFO contents and running status.
    do_reset();
    bus1.msg_ready_in = 1'b0;
    rb = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C};
    foreach (rb[i]) send_byte(rb[i]);
    check("pre-reset valid", 32'(bus1.msg_valid_out), 32'd1);
    do_reset();
    check("mid reset valid", 32'(bus1.msg_valid_out), 32'd0);
    check("mid reset msg", 32'(bus1.msg_out), 32'd0);
    check("mid reset overflow", 32'(bus1.overflow_out), 32'd0);
    bus1.msg_ready_in = 1'b1;
    send_byte(8'h64);
    repeat (6) step();
    check_q("after reset", 1'b0);

    // Random byte stream against the reference model, random consumer stalls.
    do_reset();
    rb.delete();
    for (int i = 0; i < 220; i++) begin
      int c;
      logic [7:0] b;
      c = int'($urandom_range(0, 99));
      if (c < 45)      b = 8'($urandom_range(0, 127));
      else if (c < 65) b = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 3))};
      else if (c < 75) b = 8'($urandom_range(248, 255));
      else if (c < 80) b = 8'hF0;
      else if (c < 85) b = 8'hF7;
      else if (c < 92) b = 8'($urandom_range(241, 243));
      else             b = 8'($urandom_range(244, 246));
      rb.push_back(b);
      model_byte(b);
    end
    rnd_done = 1'b0;
    fork
      begin
        foreach (rb[i]) send_byte(rb[i]);
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        step();
        bus1.msg_ready_in = ($urandom_range(0, 3) != 0);
        bus2.msg_ready_in = ($urandom_range(0, 3) != 0);
      end
    join
    bus1.msg_ready_in = 1'b1;
    bus2.msg_ready_in = 1'b1;
    repeat (10) step();
    check_q("random all", 1'b0);
    check_q("random ch0", 1'b1);
    check("random overflow", 32'(bus1.overflow_out), 32'd0);
    check("random overflow ch0", 32'(bus2.overflow_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
